// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and defaults for the unified-memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LD  = 1'b1
   } owner_e;

   localparam int MEM_LAT_DEF    = 2;
   localparam int STARVE_MAX_DEF = 4;
   // Wide enough for MEM_LAT up to 15
   localparam int WAIT_W         = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - CPU-priority pick with a saturating loader starvation counter
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic   clk,
   input  logic   Reset,
   input  logic   in_idle,
   input  logic   cpu_req,
   input  logic   ld_req,
   output logic   win_valid,
   output owner_e win_owner
);
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic          starved;

   assign starved = (starve_cnt_q == SW'(STARVE_MAX));

   always_comb begin
      win_valid    = in_idle && (cpu_req || ld_req);
      win_owner    = (ld_req && (!cpu_req || starved)) ? OWN_LD : OWN_CPU;
      starve_cnt_d = starve_cnt_q;
      // Only the arbitration cycle moves the counter; a lone ld_req blip mid-access is ignored
      if (in_idle) begin
         if (!ld_req || win_owner == OWN_LD) begin
            starve_cnt_d = '0;
         end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port memory between CPU and loader, one access at a time
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = MEM_LAT_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_done,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              we_q, we_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              cpu_gnt_q, cpu_gnt_d, ld_gnt_q, ld_gnt_d;
   logic              cpu_done_q, cpu_done_d, ld_done_q, ld_done_d;
   logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ld_rdata_q, ld_rdata_d;
   logic              win_valid;
   owner_e            win_owner;

   mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .clk       (clk),
      .Reset     (Reset),
      .in_idle   (state_q == IDLE),
      .cpu_req   (cpu_req),
      .ld_req    (ld_req),
      .win_valid (win_valid),
      .win_owner (win_owner)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      wait_d      = wait_q;
      cpu_gnt_d   = 1'b0;
      ld_gnt_d    = 1'b0;
      cpu_done_d  = 1'b0;
      ld_done_d   = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      cpu_rdata_d = cpu_rdata_q;
      ld_rdata_d  = ld_rdata_q;
      case (state_q)
         IDLE: begin
            // The registered mem_* strobe is the latched copy the ISSUE cycle presents
            if (win_valid) begin
               state_d = ISSUE;
               owner_d = win_owner;
               if (win_owner == OWN_LD) begin
                  we_d        = ld_we;
                  mem_addr_d  = ld_addr;
                  mem_wdata_d = ld_wdata;
                  ld_gnt_d    = 1'b1;
               end else begin
                  we_d        = cpu_we;
                  mem_addr_d  = cpu_addr;
                  mem_wdata_d = cpu_wdata;
                  cpu_gnt_d   = 1'b1;
               end
               mem_en_d = 1'b1;
               mem_we_d = we_d;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            wait_d  = WAIT_W'(MEM_LAT - 1);
         end
         WAIT: begin
            if (wait_q == '0) begin
               state_d = DONE;
               if (owner_q == OWN_LD) begin
                  ld_done_d = 1'b1;
                  if (!we_q) ld_rdata_d = mem_rdata;
               end else begin
                  cpu_done_d = 1'b1;
                  if (!we_q) cpu_rdata_d = mem_rdata;
               end
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_CPU;
         we_q        <= 1'b0;
         wait_q      <= '0;
         cpu_gnt_q   <= 1'b0;
         ld_gnt_q    <= 1'b0;
         cpu_done_q  <= 1'b0;
         ld_done_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         ld_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         wait_q      <= wait_d;
         cpu_gnt_q   <= cpu_gnt_d;
         ld_gnt_q    <= ld_gnt_d;
         cpu_done_q  <= cpu_done_d;
         ld_done_q   <= ld_done_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         ld_rdata_q  <= ld_rdata_d;
      end
   end

   assign cpu_gnt   = cpu_gnt_q;
   assign ld_gnt    = ld_gnt_q;
   assign cpu_done  = cpu_done_q;
   assign ld_done   = ld_done_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ld_rdata  = ld_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != IDLE);

endmodule
